crc32_checker: RTL and testbench

Byte-stream CRC-32 (IEEE 802.3, reflected, poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) frame checker: the receive-side counterpart of the crc32 generator. It accepts a frame of payload bytes followed by the 4-byte FCS (little-endian, LSB first) over a valid/ready stream, recomputes the CRC over the payload bit-serially, and reports pass/fail plus the computed and received values. It sits between the byte receive path and the register interface of the peripheral.

---
 rtl/crc32_checker_if.sv | 36 +++
 rtl/crc32_checker.sv | 207 ++++++++++++++++++++
 tb/tb_crc32_checker.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc32_checker_if.sv
// ---------------------------------------------------------------------------
// crc32_checker_if
//
// Byte stream carrying a received frame into the CRC-32 checker.
//
// Handshake: a byte transfers on a rising clock edge when in_valid and
// in_ready are both 1. A source may hold in_valid high while in_ready is 0.
// in_data and in_last only have meaning while in_valid is 1. in_last marks
// the final FCS byte of a frame.
//
// Signals
//   in_data   8  received byte            (master -> slave)
//   in_valid  1  in_data valid            (master -> slave)
//   in_last   1  final FCS byte of frame  (master -> slave)
//   in_ready  1  slave accepts this cycle (slave -> master)
// ---------------------------------------------------------------------------
interface crc32_checker_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/crc32_checker.sv
// ---------------------------------------------------------------------------
// crc32_checker
//
// Receive-side CRC-32 (IEEE 802.3, reflected, poly 0xEDB88320, init
// 0xFFFFFFFF, final XOR 0xFFFFFFFF) frame checker. A frame is payload
// bytes followed by a 4-byte little-endian FCS. The CRC is recomputed over
// the payload one bit per cycle and compared with the received FCS.
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset
//   in_if           byte stream (slave side of crc32_checker_if)
//   busy_o          frame in progress (FILL/ACCEPT/SHIFT/CHECK)
//   result_valid_o  result fields valid, held until next frame starts
//   crc_ok_o        frame complete, length >= 4, crc_calc == crc_rx
//   crc_err_o       frame complete and not ok (includes runt)
//   len_err_o       frame ended with fewer than 4 bytes
//   crc_calc_o      CRC over payload with final XOR applied
//   crc_rx_o        received FCS {byte3,byte2,byte1,byte0}
//   data_len_o      payload byte count, saturates at 0xFFFF
//   state_o         current FSM state (debug)
// ---------------------------------------------------------------------------
module crc32_checker (
  input  logic                  clk,
  input  logic                  rst,
  crc32_checker_if.slave        in_if,
  output logic                  busy_o,
  output logic                  result_valid_o,
  output logic                  crc_ok_o,
  output logic                  crc_err_o,
  output logic                  len_err_o,
  output logic [31:0]           crc_calc_o,
  output logic [31:0]           crc_rx_o,
  output logic [15:0]           data_len_o,
  output logic [2:0]            state_o
);

  localparam logic [31:0] POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    ACCEPT = 3'd2,
    SHIFT  = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  // Delay line: newest byte enters at [31:24], oldest sits at [7:0]. Once
  // four bytes are held it is already in FCS order {b3,b2,b1,b0}.
  logic [31:0] dly_q, dly_d;
  logic [2:0]  fill_q, fill_d;
  logic [2:0]  bit_q, bit_d;
  logic        last_q, last_d;
  logic [15:0] len_q, len_d;
  logic [31:0] calc_q, calc_d;
  logic [31:0] rx_q, rx_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        lerr_q, lerr_d;
  logic        ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= CRC_INIT;
      dly_q   <= 32'h0;
      fill_q  <= 3'd0;
      bit_q   <= 3'd0;
      last_q  <= 1'b0;
      len_q   <= 16'h0;
      calc_q  <= 32'h0;
      rx_q    <= 32'h0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      dly_q   <= dly_d;
      fill_q  <= fill_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      len_q   <= len_d;
      calc_q  <= calc_d;
      rx_q    <= rx_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      lerr_q  <= lerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    dly_d   = dly_q;
    fill_d  = fill_q;
    bit_d   = bit_q;
    last_d  = last_q;
    len_d   = len_q;
    calc_d  = calc_q;
    rx_d    = rx_q;
    ok_d    = ok_q;
    err_d   = err_q;
    lerr_d  = lerr_q;
    ready   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        ready = 1'b1;
        if (in_if.in_valid) begin
          // First byte of a new frame clears the previous result.
          crc_d  = CRC_INIT;
          fill_d = 3'd1;
          len_d  = 16'h0;
          calc_d = 32'h0;
          rx_d   = 32'h0;
          ok_d   = 1'b0;
          err_d  = 1'b0;
          lerr_d = 1'b0;
          dly_d  = {in_if.in_data, 24'h0};
          if (in_if.in_last) begin
            state_d = DONE;
            lerr_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        ready = 1'b1;
        if (in_if.in_valid) begin
          dly_d  = {in_if.in_data, dly_q[31:8]};
          fill_d = fill_q + 3'd1;
          if (in_if.in_last) begin
            if (fill_q == 3'd3) begin
              // Exactly four bytes: FCS only, empty payload.
              state_d = CHECK;
            end else begin
              state_d = DONE;
              lerr_d  = 1'b1;
              err_d   = 1'b1;
              calc_d  = 32'h0;
              rx_d    = 32'h0;
            end
          end else if (fill_q == 3'd3) begin
            state_d = ACCEPT;
          end
        end
      end

      ACCEPT: begin
        ready = 1'b1;
        if (in_if.in_valid) begin
          // The byte leaving the delay line is now known to be payload.
          crc_d  = crc_q ^ {24'h0, dly_q[7:0]};
          dly_d  = {in_if.in_data, dly_q[31:8]};
          if (len_q != 16'hFFFF) begin
            len_d = len_q + 16'd1;
          end
          bit_d   = 3'd0;
          last_d  = in_if.in_last;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        crc_d = crc_q[0] ? ((crc_q >> 1) ^ POLY) : (crc_q >> 1);
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = last_q ? CHECK : ACCEPT;
        end
      end

      CHECK: begin
        calc_d  = ~crc_q;
        rx_d    = dly_q;
        ok_d    = (~crc_q == dly_q);
        err_d   = (~crc_q != dly_q);
        lerr_d  = 1'b0;
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_if.in_ready = ready;
  assign busy_o         = (state_q == FILL) || (state_q == ACCEPT) ||
                          (state_q == SHIFT) || (state_q == CHECK);
  assign result_valid_o = (state_q == DONE);
  assign crc_ok_o       = ok_q;
  assign crc_err_o      = err_q;
  assign len_err_o      = lerr_q;
  assign crc_calc_o     = calc_q;
  assign crc_rx_o       = rx_q;
  assign data_len_o     = len_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_crc32_checker.sv
// ---------------------------------------------------------------------------
// tb_crc32_checker
//
// Directed frames with hand-computed CRC results. Drivers push the expected
// result when a frame starts and the expected result cycle when its last
// byte is accepted; a monitor pops and compares when result_valid rises.
// ---------------------------------------------------------------------------
module tb_crc32_checker;

  typedef struct packed {
    logic        ok;
    logic        err;
    logic        lerr;
    logic [31:0] calc;
    logic [31:0] rx;
    logic [15:0] dlen;
    logic        calc_ne;   // calc must differ from the value given
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic        clk;
  logic        rst;
  logic        busy;
  logic        result_valid;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;
  logic [31:0] crc_calc;
  logic [31:0] crc_rx;
  logic [15:0] data_len;
  logic [2:0]  state;

  crc32_checker_if bus ();

  crc32_checker dut (
    .clk            (clk),
    .rst            (rst),
    .in_if          (bus),
    .busy_o         (busy),
    .result_valid_o (result_valid),
    .crc_ok_o       (crc_ok),
    .crc_err_o      (crc_err),
    .len_err_o      (len_err),
    .crc_calc_o     (crc_calc),
    .crc_rx_o       (crc_rx),
    .data_len_o     (data_len),
    .state_o        (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [7:0]       frm[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic ok, input logic err, input logic lerr,
                                  input logic [31:0] calc, input logic [31:0] rx,
                                  input logic [15:0] dlen, input logic calc_ne);
    exp_t e;
    e.ok = ok; e.err = err; e.lerr = lerr; e.calc = calc;
    e.rx = rx; e.dlen = dlen; e.calc_ne = calc_ne;
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic prev_rv = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (!rst) begin
      checks++;
      if (result_valid ? ((crc_ok ^ crc_err) !== 1'b1) : ((crc_ok | crc_err) !== 1'b0)) begin
        errors++;
        $display("FAIL flag_excl: rv=%0b ok=%0b err=%0b", result_valid, crc_ok, crc_err);
      end
      if (result_valid && !prev_rv) begin
        if (exp_q.size() == 0 || exp_cyc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: result_valid rose at cycle %0d with nothing expected", cyc);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("latency_cycle", cyc, c);
          chk("crc_ok", {31'h0, crc_ok}, {31'h0, e.ok});
          chk("crc_err", {31'h0, crc_err}, {31'h0, e.err});
          chk("len_err", {31'h0, len_err}, {31'h0, e.lerr});
          chk("crc_rx", crc_rx, e.rx);
          chk("data_len", {16'h0, data_len}, {16'h0, e.dlen});
          if (e.calc_ne) begin
            checks++;
            if (crc_calc === e.calc) begin
              errors++;
              $display("FAIL crc_calc_differs: got 0x%0h required a value other than 0x%0h", crc_calc, e.calc);
            end
          end else begin
            chk("crc_calc", crc_calc, e.calc);
          end
        end
      end
    end
    prev_rv = result_valid;
  end

  // ---------------- driver tasks ----------------
  // Entered at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] d, input bit last, input bit junk, input int lat);
    int n = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      bus.in_data = junk ? 8'hEE : d;
      bus.in_last = junk ? 1'b1 : last;
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1 within 50 cycles", bus.in_ready);
    end
    bus.in_data = d;
    bus.in_last = last;
    if (last) exp_cyc_q.push_back(cyc + lat);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_frame(input exp_t e, input int lat, input bit junk, input int maxgap);
    int n;
    exp_q.push_back(e);
    for (int i = 0; i < frm.size(); i++) begin
      if (maxgap > 0) begin
        n = $urandom_range(0, maxgap);
        repeat (n) @(negedge clk);
      end
      send_byte(frm[i], (i == frm.size() - 1), junk, lat);
    end
    n = 0;
    while (!result_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: result_valid=%0b required 1 within 30 cycles", result_valid);
    end
  endtask

  task automatic load_std();
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_result_valid", {31'h0, result_valid}, 32'h0);
    chk("rst_flags", {29'h0, crc_ok, crc_err, len_err}, 32'h0);
    chk("rst_crc_calc", crc_calc, 32'h0);
    chk("rst_crc_rx", crc_rx, 32'h0);
    chk("rst_data_len", {16'h0, data_len}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values();

    // "123456789" with correct FCS, in_valid held
    load_std();
    run_frame(mk_exp(1, 0, 0, 32'hCBF43926, 32'hCBF43926, 16'd9, 0), 10, 0, 0);

    // payload byte 5 corrupted 0x35 -> 0x34
    load_std();
    frm[4] = 8'h34;
    run_frame(mk_exp(0, 1, 0, 32'hCBF43926, 32'hCBF43926, 16'd9, 1), 10, 0, 0);

    // good payload, wrong FCS low byte
    load_std();
    frm[9] = 8'h27;
    run_frame(mk_exp(0, 1, 0, 32'hCBF43926, 32'hCBF43927, 16'd9, 0), 10, 0, 0);

    // empty payload, FCS of nothing is 0
    frm = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(mk_exp(1, 0, 0, 32'h0, 32'h0, 16'd0, 0), 2, 0, 0);

    // runt, first byte taken in the DONE cycle of the previous frame
    frm = '{8'hAA, 8'hBB, 8'hCC};
    run_frame(mk_exp(0, 1, 1, 32'h0, 32'h0, 16'd0, 0), 1, 0, 0);
    chk("runt_in_ready", {31'h0, bus.in_ready}, 32'h1);

    // "a" -> 0xE8B7BE43
    frm = '{8'h61, 8'h43, 8'hBE, 8'hB7, 8'hE8};
    run_frame(mk_exp(1, 0, 0, 32'hE8B7BE43, 32'hE8B7BE43, 16'd1, 0), 10, 0, 0);

    // gapped in_valid, junk offered while in_ready=0
    load_std();
    run_frame(mk_exp(1, 0, 0, 32'hCBF43926, 32'hCBF43926, 16'd9, 0), 10, 1, 2);

    // "abc" -> 0x352441C2
    frm = '{8'h61, 8'h62, 8'h63, 8'hC2, 8'h41, 8'h24, 8'h35};
    run_frame(mk_exp(1, 0, 0, 32'h352441C2, 32'h352441C2, 16'd3, 0), 10, 0, 0);

    // reset during SHIFT: no result expected for the aborted frame
    repeat (2) @(negedge clk);
    load_std();
    for (int i = 0; i < 5; i++) send_byte(frm[i], 1'b0, 1'b0, 0);
    chk("shift_busy", {31'h0, busy}, 32'h1);
    chk("shift_in_ready", {31'h0, bus.in_ready}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values();
    repeat (12) @(negedge clk);
    chk("abort_no_result", {31'h0, result_valid}, 32'h0);

    load_std();
    run_frame(mk_exp(1, 0, 0, 32'hCBF43926, 32'hCBF43926, 16'd9, 0), 10, 0, 0);

    repeat (3) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end

endmodule
